// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch stage: fetch FSM encoding,
// the pipeline bubble encoding and the default boot address.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  // ADDI x0,x0,0 -- also used by the ID stage when it flushes
  localparam logic [31:0] IFU_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] IFU_RESET_PC  = 32'h0000_0000;

  // Sequential PC advance; wraps from 32'hFFFF_FFFC to 0
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory READ/BUSYWAIT bus. The fetch unit is the master; the
// memory completes an access on a posedge where READ=1 and BUSYWAIT=0.
interface instruction_fetch_unit_if;

  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_BUSYWAIT;

  modport master (
    output IMEM_READ,
    output IMEM_ADDR,
    input  IMEM_RDATA,
    input  IMEM_BUSYWAIT
  );

  modport slave (
    input  IMEM_READ,
    input  IMEM_ADDR,
    output IMEM_RDATA,
    output IMEM_BUSYWAIT
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc,instr,valid} holding register that parks a fetched word
// while the decode stage is stalled.
module fetch_skid_buffer
  import ifu_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = IFU_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic        drain,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end else if (clear || drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= 32'd0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues one word read at a time, absorbs memory
// latency and feeds the IF/ID register, honouring stalls and EX redirects.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
  parameter logic [31:0] NOP_INSTR = IFU_NOP_INSTR
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  instruction_fetch_unit_if.master imem,
  input  logic                     STALL,
  input  logic                     BRANCH_TAKEN,
  input  logic [31:0]              BRANCH_TARGET,
  output logic [31:0]              IF_ID_PC,
  output logic [31:0]              IF_ID_INSTR,
  output logic                     IF_ID_VALID,
  output logic                     FETCH_MISALIGN,
  output logic [31:0]              FETCH_COUNT
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         read_q, read_d;
  logic         kill_q, kill_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic [31:0]  if_id_pc_q, if_id_pc_d;
  logic [31:0]  if_id_instr_q, if_id_instr_d;
  logic         if_id_valid_q, if_id_valid_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  count_q, count_d;

  logic         skid_load, skid_clear, skid_drain;
  logic [31:0]  skid_pc, skid_instr;
  logic         skid_valid;

  logic [31:0]  target_aligned;
  logic         complete;

  assign target_aligned = {BRANCH_TARGET[31:2], 2'b00};
  // READ is only ever high in S_REQ, so this is the memory completion edge
  assign complete       = read_q && !imem.IMEM_BUSYWAIT;

  fetch_skid_buffer #(
    .NOP_INSTR (NOP_INSTR)
  ) u_skid (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .load      (skid_load),
    .clear     (skid_clear),
    .drain     (skid_drain),
    .pc_in     (pc_q),
    .instr_in  (imem.IMEM_RDATA),
    .pc_out    (skid_pc),
    .instr_out (skid_instr),
    .valid_out (skid_valid)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    read_d        = read_q;
    kill_d        = kill_q;
    redir_pc_d    = redir_pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    misalign_d    = 1'b0;
    count_d       = count_q;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    skid_drain    = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        read_d  = 1'b1;
        if (BRANCH_TAKEN) pc_d = target_aligned;
      end

      S_REQ: begin
        // Cycles that deliver nothing become bubbles unless decode is holding
        if (!STALL) if_id_valid_d = 1'b0;
        if (complete) begin
          if (BRANCH_TAKEN) begin
            pc_d   = target_aligned;
            kill_d = 1'b0;
          end else if (kill_q) begin
            pc_d   = redir_pc_q;
            kill_d = 1'b0;
          end else if (STALL) begin
            skid_load = 1'b1;
            pc_d      = pc_plus4(pc_q);
            state_d   = S_HOLD;
            read_d    = 1'b0;
          end else begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem.IMEM_RDATA;
            if_id_valid_d = 1'b1;
            count_d       = count_q + 32'd1;
            pc_d          = pc_plus4(pc_q);
          end
        end else if (BRANCH_TAKEN) begin
          // Address must stay put until the memory finishes; refetch afterwards
          kill_d     = 1'b1;
          redir_pc_d = target_aligned;
        end
      end

      S_HOLD: begin
        if (BRANCH_TAKEN) begin
          pc_d    = target_aligned;
          state_d = S_REQ;
          read_d  = 1'b1;
        end else if (!STALL) begin
          if_id_pc_d    = skid_pc;
          if_id_instr_d = skid_instr;
          if_id_valid_d = skid_valid;
          if (skid_valid) count_d = count_q + 32'd1;
          skid_drain = 1'b1;
          state_d    = S_REQ;
          read_d     = 1'b1;
        end
      end

      default: begin
        state_d = S_BOOT;
        read_d  = 1'b0;
      end
    endcase

    // A redirect flushes IF/ID and the parked word regardless of STALL
    if (BRANCH_TAKEN) begin
      if_id_pc_d    = 32'd0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      skid_clear    = 1'b1;
      misalign_d    = |BRANCH_TARGET[1:0];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      read_q        <= 1'b0;
      kill_q        <= 1'b0;
      redir_pc_q    <= RESET_PC;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      count_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      read_q        <= read_d;
      kill_q        <= kill_d;
      redir_pc_q    <= redir_pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      misalign_q    <= misalign_d;
      count_q       <= count_d;
    end
  end

  // The PC register doubles as the request address; it only moves between accesses
  assign imem.IMEM_READ = read_q;
  assign imem.IMEM_ADDR = pc_q;

  assign IF_ID_PC       = if_id_pc_q;
  assign IF_ID_INSTR    = if_id_instr_q;
  assign IF_ID_VALID    = if_id_valid_q;
  assign FETCH_MISALIGN = misalign_q;
  assign FETCH_COUNT    = count_q;

endmodule
